fpga_ram_be: RTL
================

FPGA_RAM_BE -- requirements
Module: fpga_ram_be

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL set word-address width; depth DEPTH = 2**ADDR_WIDTH words of 32 bits.
REQ-002 Parameter INIT_ZERO, default 0, SHALL, when 1, start memory contents at all-zero at configuration; when 0, initial contents are undefined.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 cs  input  1  SHALL be the access request, sampled each cycle.
REQ-006 we  input  4  SHALL be byte-lane write enables; bit i covers write_data[8i+7:8i]; we = 0 means read.
REQ-007 address  input  ADDR_WIDTH  SHALL be the word address.
REQ-008 write_data  input  32  SHALL be the write data.
REQ-009 read_data  output  32  SHALL be the registered read data.
REQ-010 ready  output  1  SHALL be a one-cycle pulse acknowledging an accepted access.
REQ-011 zeroise  input  1  SHALL be the memory-clear request.
REQ-012 busy  output  1  SHALL be high while a zeroise sweep runs.

Function
REQ-013 Access is accepted in cycle N when cs = 1, FSM is IDLE and zeroise = 0; ready SHALL be 1 in cycle N+1 only.
REQ-014 Accepted read: read_data SHALL show mem[address] in cycle N+1 and hold it until the next accepted read or zeroise start.
REQ-015 Accepted write: only lanes with we[i] = 1 SHALL update at the cycle-N edge; other lanes keep their contents; read_data SHALL hold its previous value.
REQ-016 Back-to-back accesses SHALL be accepted every cycle; a read in N+1 of a word written in N SHALL return the new data.
REQ-017 Address SHALL be used modulo DEPTH with no out-of-range behaviour.
REQ-018 FSM states: IDLE, ZERO.
REQ-019 IDLE -> ZERO when zeroise = 1: counter SHALL load 0, busy SHALL go 1, and read_data SHALL clear to 0 on that edge.
REQ-020 In ZERO, each cycle SHALL write 0 to mem[counter] and increment counter; after writing DEPTH-1, ZERO -> IDLE.
REQ-021 A sweep SHALL take exactly DEPTH cycles with busy = 1; busy SHALL drop in the cycle after the DEPTH-1 write.
REQ-022 In ZERO, cs SHALL be ignored: no write, no read_data update, ready = 0.
REQ-023 If zeroise and cs are both 1 in IDLE, zeroise SHALL win and the access is dropped (no ready).
REQ-024 zeroise asserted during ZERO SHALL be ignored; the sweep is not restarted.
REQ-025 Counter SHALL be ADDR_WIDTH bits and SHALL not wrap past DEPTH-1 within a sweep.

Reset
REQ-026 reset_n low SHALL immediately force ready = 0, busy = 0, read_data = 0, FSM = IDLE, counter = 0.
REQ-027 Memory array SHALL not be reset; reset mid-sweep leaves it partially cleared, and no sweep resumes after reset.
REQ-028 The first access SHALL be accepted on the first rising edge with reset_n high.

Configuration
REQ-029 Macro FPGA_RAM_BE_ZEROISE_EN defined: zeroise FSM and counter SHALL be built as specified in REQ-018..REQ-025.
REQ-030 Macro undefined: zeroise SHALL be ignored, busy SHALL be constant 0, FSM and counter SHALL be absent, and access behaviour SHALL be unchanged.

Verification
REQ-031 Reset, write 0xDEADBEEF to address 0x005 with we = 0xF, then read 0x005 -> ready pulses 1 cycle after each access; read_data = 0xDEADBEEF.
REQ-032 Write 0x11223344 to address 0x010 with we = 0xF, write 0xAABBCCDD to 0x010 with we = 0x5, read 0x010 -> read_data = 0x11BB33DD.
REQ-033 Write 0x01 to address 0x001, then immediately write 0x02 to address 0x002, then read 0x001 and read 0x002 back-to-back -> ready high 4 consecutive cycles; read_data = 0x01, then 0x02.
REQ-034 With ZEROISE_EN and ADDR_WIDTH = 4, fill all words, pulse zeroise together with cs -> no ready, busy high exactly 16 cycles, cs ignored while busy, all words read 0 afterwards.
REQ-035 With ZEROISE_EN, start a sweep and assert reset_n low at sweep cycle 5 -> busy = 0 and ready = 0 immediately; words 0..4 read 0, word 8 keeps its old value.
REQ-036 Without ZEROISE_EN, pulse zeroise -> busy stays 0 and memory contents are unchanged.

Source files
------------

// File: rtl/fpga_ram_be.sv
// Single-port 32-bit RAM with byte-lane write enables and a registered read port.
// Optional zeroise sweep built only when FPGA_RAM_BE_ZEROISE_EN is defined.
module fpga_ram_be #(
  parameter int ADDR_WIDTH = 12,
  parameter bit INIT_ZERO  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  ready,
  input  logic                  zeroise,
  output logic                  busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic                  accept;
  logic                  rd_accept;
  logic                  clr_rd;
  logic [3:0]            mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           rd_word;
  logic [31:0]           rdata_q;
  logic                  ready_q;

`ifdef FPGA_RAM_BE_ZEROISE_EN
  typedef enum logic {S_IDLE, S_ZERO} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // The sweep owns the memory port while in S_ZERO; host accesses are dropped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    clr_rd    = 1'b0;
    mem_we    = 4'h0;
    mem_addr  = address;
    mem_wdata = write_data;
    case (state_q)
      S_IDLE: begin
        if (zeroise) begin
          state_d = S_ZERO;
          cnt_d   = '0;
          clr_rd  = 1'b1;
        end else begin
          accept = cs;
          mem_we = cs ? we : 4'h0;
        end
      end
      S_ZERO: begin
        mem_we    = 4'hF;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        if (&cnt_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_ZERO);
`else
  logic unused_zeroise;

  assign unused_zeroise = zeroise;
  assign accept    = cs;
  assign clr_rd    = 1'b0;
  assign mem_we    = cs ? we : 4'h0;
  assign mem_addr  = address;
  assign mem_wdata = write_data;
  assign busy      = 1'b0;
`endif

  assign rd_accept = accept && (we == 4'h0);

  // Storage is never reset; INIT_ZERO only selects the configuration-time image.
  if (INIT_ZERO) begin : g_mem_init
    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end

    assign rd_word = mem[address];
  end else begin : g_mem
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end

    assign rd_word = mem[address];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= accept;
      if (clr_rd)         rdata_q <= '0;
      else if (rd_accept) rdata_q <= rd_word;
    end
  end

  assign read_data = rdata_q;
  assign ready     = ready_q;

endmodule
